// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD counter / seven-segment display slice.
// Glyph bits are ordered A..G with segment A in bit 0; a set bit means the segment is lit.
package seg7_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } repeat_state_t;

  localparam int unsigned BCD_MAX_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Elaboration-time decimal to packed BCD, digit 0 in the low nibble.
  function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int unsigned value);
    logic [4*BCD_MAX_DIGITS-1:0] bcd;
    int unsigned                 v;
    bcd = '0;
    v   = value;
    for (int unsigned k = 0; k < BCD_MAX_DIGITS; k++) begin
      bcd[4*k +: 4] = 4'(v % 10);
      v             = v / 10;
    end
    return bcd;
  endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// One BCD digit to a registered seven-segment pattern; codes 10-15 show blank.
// SEG_ACTIVE_LOW=1 inverts the outputs so a lit segment drives 0.
module seg7_digit_decoder
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segments <= SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;
    end else begin
      segments <= SEG_ACTIVE_LOW ? ~glyph : glyph;
    end
  end

endmodule

// File: rtl/bcd_counter_7seg.sv
// Multi-digit BCD up/down counter stepped by debounced buttons, wrapping at MAX_COUNT,
// with registered seven-segment outputs. Define AUTO_REPEAT_EN for hold-to-repeat stepping.
module bcd_counter_7seg
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned MAX_COUNT      = 99,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned REPEAT_DELAY   = 12500000,
  parameter int unsigned REPEAT_PERIOD  = 2500000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Incr,
  input  logic                    i_Decr,
  output logic [4*NUM_DIGITS-1:0] o_Count,
  output logic                    o_Wrap,
  output logic [7*NUM_DIGITS-1:0] o_Segments
);

  localparam logic [4*BCD_MAX_DIGITS-1:0] MAX_BCD_ALL = to_bcd(MAX_COUNT);
  localparam logic [4*NUM_DIGITS-1:0]     MAX_BCD     = MAX_BCD_ALL[4*NUM_DIGITS-1:0];

  logic                    prev_incr;
  logic                    prev_decr;
  logic                    rise_up;
  logic                    rise_dn;
  logic                    step_up;
  logic                    step_dn;
  logic [4*NUM_DIGITS-1:0] count_inc;
  logic [4*NUM_DIGITS-1:0] count_dec;
  logic [4*NUM_DIGITS-1:0] count_next;
  logic                    wrap_next;
  logic                    carry;
  logic                    borrow;
  bcd_digit_t              digit;

  // Edge registers also load during reset, so a button held through reset release is not a press.
  always_ff @(posedge i_Clk) begin
    prev_incr <= i_Incr;
    prev_decr <= i_Decr;
  end

  assign rise_up = i_Incr & ~prev_incr;
  assign rise_dn = i_Decr & ~prev_decr;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned TIMER_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TIMER_W     = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] req;
  logic       both_held;

  assign level     = {i_Decr, i_Incr};
  assign rise      = {rise_dn, rise_up};
  assign both_held = i_Incr & i_Decr;

  // Index 0 handles the increment button, index 1 the decrement button.
  for (genvar d = 0; d < 2; d++) begin : g_repeat
    repeat_state_t      state;
    repeat_state_t      state_next;
    logic [TIMER_W-1:0] timer;
    logic               timer_clr;
    logic               step_req;

    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        state <= RPT_IDLE;
        timer <= '0;
      end else begin
        state <= state_next;
        timer <= timer_clr ? '0 : timer + 1'b1;
      end
    end

    always_comb begin
      state_next = state;
      if (both_held) begin
        state_next = RPT_IDLE;
      end else begin
        case (state)
          RPT_IDLE:   if (rise[d]) state_next = RPT_HOLD;
          RPT_HOLD: begin
            if (!level[d])                state_next = RPT_IDLE;
            else if (timer == DELAY_LAST) state_next = RPT_REPEAT;
          end
          RPT_REPEAT: if (!level[d]) state_next = RPT_IDLE;
          default:    state_next = RPT_IDLE;
        endcase
      end
    end

    always_comb begin
      step_req  = 1'b0;
      timer_clr = 1'b0;
      if (!both_held) begin
        case (state)
          RPT_IDLE: begin
            timer_clr = 1'b1;
            step_req  = rise[d];
          end
          RPT_HOLD: begin
            step_req  = level[d] && (timer == DELAY_LAST);
            timer_clr = step_req;
          end
          RPT_REPEAT: begin
            step_req  = level[d] && (timer == PERIOD_LAST);
            timer_clr = step_req;
          end
          default: timer_clr = 1'b1;
        endcase
      end
    end

    assign req[d] = step_req;
  end

  assign step_up = req[0] & ~req[1];
  assign step_dn = req[1] & ~req[0];
`else
  assign step_up = rise_up & ~rise_dn;
  assign step_dn = rise_dn & ~rise_up;
`endif

  // Ripple carry/borrow digit by digit so every digit stays within 0..9.
  always_comb begin
    count_inc = o_Count;
    count_dec = o_Count;
    carry     = 1'b1;
    borrow    = 1'b1;
    digit     = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      digit = o_Count[4*k +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          count_inc[4*k +: 4] = '0;
        end else begin
          count_inc[4*k +: 4] = digit + 4'd1;
          carry               = 1'b0;
        end
      end
      if (borrow) begin
        if (digit == 4'd0) begin
          count_dec[4*k +: 4] = 4'd9;
        end else begin
          count_dec[4*k +: 4] = digit - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_next = o_Count;
    wrap_next  = 1'b0;
    if (step_up) begin
      if (o_Count == MAX_BCD) begin
        count_next = '0;
        wrap_next  = 1'b1;
      end else begin
        count_next = count_inc;
      end
    end else if (step_dn) begin
      if (o_Count == '0) begin
        count_next = MAX_BCD;
        wrap_next  = 1'b1;
      end else begin
        count_next = count_dec;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Count <= '0;
      o_Wrap  <= 1'b0;
    end else begin
      o_Count <= count_next;
      o_Wrap  <= wrap_next;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    seg7_digit_decoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_decoder (
      .clk     (i_Clk),
      .rst     (i_Rst),
      .digit   (o_Count[4*k +: 4]),
      .segments(o_Segments[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_bcd_counter_7seg.sv
// Bench for bcd_counter_7seg: two instances (MAX 99 active-low, MAX 59 active-high) share the
// buttons; a binary reference model predicts every cycle and a scoreboard queue holds predictions.
module tb_bcd_counter_7seg;

  logic        clk = 1'b0;
  logic        rst;
  logic        incr;
  logic        decr;
  logic [7:0]  count99;
  logic [7:0]  count59;
  logic        wrap99;
  logic        wrap59;
  logic [13:0] seg99;
  logic [13:0] seg59;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef AUTO_REPEAT_EN
  localparam int DLY = 10;
  localparam int PER = 4;
  bit act_u = 1'b0;
  bit act_d = 1'b0;
  int len_u = 0;
  int len_d = 0;
`endif

  typedef struct {
    bit rst;
    int c99;
    bit w99;
    int c59;
    bit w59;
  } exp_t;

  exp_t sb[$];

  int m99 = 0;
  int m59 = 0;
  bit mw99 = 1'b0;
  bit mw59 = 1'b0;
  bit prev_inc = 1'b0;
  bit prev_dec = 1'b0;
  int prev99 = 0;
  int prev59 = 0;

  always #5 clk = ~clk;

  bcd_counter_7seg #(
    .NUM_DIGITS    (2),
    .MAX_COUNT     (99),
    .SEG_ACTIVE_LOW(1'b1),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Incr    (incr),
    .i_Decr    (decr),
    .o_Count   (count99),
    .o_Wrap    (wrap99),
    .o_Segments(seg99)
  );

  bcd_counter_7seg #(
    .NUM_DIGITS    (2),
    .MAX_COUNT     (59),
    .SEG_ACTIVE_LOW(1'b0),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4)
  ) dut59 (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Incr    (incr),
    .i_Decr    (decr),
    .o_Count   (count59),
    .o_Wrap    (wrap59),
    .o_Segments(seg59)
  );

  function automatic logic [7:0] to_bcd2(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0:       return 7'h3F;
      1:       return 7'h06;
      2:       return 7'h5B;
      3:       return 7'h4F;
      4:       return 7'h66;
      5:       return 7'h6D;
      6:       return 7'h7D;
      7:       return 7'h07;
      8:       return 7'h7F;
      9:       return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] seg_of(input int v);
    return {glyph(v / 10), glyph(v % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_model(inout int cnt, output bit wrap, input int max,
                            input bit up, input bit dn, input bit r);
    wrap = 1'b0;
    if (r) begin
      cnt = 0;
    end else if (up) begin
      if (cnt == max) begin cnt = 0; wrap = 1'b1; end
      else cnt = cnt + 1;
    end else if (dn) begin
      if (cnt == 0) begin cnt = max; wrap = 1'b1; end
      else cnt = cnt - 1;
    end
  endtask

`ifdef AUTO_REPEAT_EN
  // Hold length counted from the press: steps at 0, DLY, DLY+PER, DLY+2*PER, ...
  task automatic rpt_dir(input bit lvl, input bit prev, inout bit act, inout int len, output bit req);
    req = 1'b0;
    if (lvl && !prev) begin
      act = 1'b1;
      len = 0;
      req = 1'b1;
    end else if (lvl && act) begin
      len = len + 1;
      if (len == DLY || (len > DLY && (len - DLY) % PER == 0)) req = 1'b1;
    end else begin
      act = 1'b0;
    end
  endtask
`endif

  // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
  task automatic tick(input bit inc, input bit dec, input bit r);
    exp_t e;
    bit   up_req;
    bit   dn_req;
    @(negedge clk);
    incr   = inc;
    decr   = dec;
    rst    = r;
    up_req = 1'b0;
    dn_req = 1'b0;
    if (r) begin
`ifdef AUTO_REPEAT_EN
      act_u = 1'b0;
      act_d = 1'b0;
`endif
    end else begin
`ifdef AUTO_REPEAT_EN
      if (inc && dec) begin
        act_u = 1'b0;
        act_d = 1'b0;
      end else begin
        rpt_dir(inc, prev_inc, act_u, len_u, up_req);
        rpt_dir(dec, prev_dec, act_d, len_d, dn_req);
      end
`else
      up_req = inc && !prev_inc;
      dn_req = dec && !prev_dec;
`endif
    end
    prev_inc = inc;
    prev_dec = dec;
    step_model(m99, mw99, 99, up_req && !dn_req, dn_req && !up_req, r);
    step_model(m59, mw59, 59, up_req && !dn_req, dn_req && !up_req, r);
    e.rst = r;
    e.c99 = m99;
    e.w99 = mw99;
    e.c59 = m59;
    e.w59 = mw59;
    sb.push_back(e);
  endtask

  task automatic press_up();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [13:0] s99;
    logic [13:0] s59;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("count99", count99, to_bcd2(e.c99));
        check_eq("wrap99", wrap99, e.w99);
        check_eq("count59", count59, to_bcd2(e.c59));
        check_eq("wrap59", wrap59, e.w59);
        s99 = ~seg_of(e.rst ? 0 : prev99);
        s59 = seg_of(e.rst ? 0 : prev59);
        check_eq("seg99", seg99, s99);
        check_eq("seg59", seg59, s59);
        prev99 = e.c99;
        prev59 = e.c59;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  initial begin : stim
    logic [13:0] s;
    rst  = 1'b1;
    incr = 1'b0;
    decr = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b1);

    // Increment held across reset release must not count.
    repeat (2) tick(1'b1, 1'b0, 1'b1);
    repeat (10) tick(1'b1, 1'b0, 1'b0);
    check_eq("t1_count", count99, 8'h00);
    check_eq("t1_wrap", wrap99, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    repeat (10) press_up();
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t2_count", count99, 8'h10);
    s = ~{7'h06, 7'h3F};
    check_eq("t2_seg99", seg99, s);
    s = {7'h06, 7'h3F};
    check_eq("t2_seg59", seg59, s);

    // Wrap at zero going down, then at the maximum going up.
    repeat (2) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t3_dn_count99", count99, 8'h99);
    check_eq("t3_dn_count59", count59, 8'h59);
    check_eq("t3_dn_wrap59", wrap59, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t3_dn_wrap_end", wrap59, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t3_up_count99", count99, 8'h00);
    check_eq("t3_up_wrap99", wrap99, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t3_up_wrap_end", wrap99, 1'b0);

    // Simultaneous presses cancel.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    repeat (42) press_up();
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t4_count", count99, 8'h42);
    check_eq("t4_wrap", wrap99, 1'b0);

    repeat (60) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
    tick(1'b0, 1'b0, 1'b0);

`ifdef AUTO_REPEAT_EN
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    repeat (30) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t5_count", count99, 8'h06);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    check_eq("t5_after_release", count99, 8'h06);
`endif

    // Reset in the middle of a press (or of auto-repeat) at 37.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < 400 && m99 != 37; i++) tick(1'b1, 1'b0, 1'b0);
`else
    for (int i = 0; i < 100 && m99 != 37; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (m99 != 37) tick(1'b0, 1'b0, 1'b0);
    end
`endif
    tick(1'b1, 1'b0, 1'b1);
    check_eq("t6_before_reset", count99, 8'h37);
    repeat (20) tick(1'b1, 1'b0, 1'b0);
    check_eq("t6_count", count99, 8'h00);
    s = ~{7'h3F, 7'h3F};
    check_eq("t6_seg99", seg99, s);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t6_fresh_press", count99, 8'h01);

    repeat (2) tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
